// File: rtl/infra_pkg.sv
// infra_pkg: shared state encodings and counter-width helper for the infrared ball path
package infra_pkg;
  typedef enum logic [1:0] {EMPTY, CONFIRM, HOLD, RELEASE} pres_e;
  typedef enum logic [1:0] {K_IDLE, K_FIRE, K_COOL} kick_e;
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/infra_kick_timer.sv
// infra_kick_timer: fixed-width kick pulse followed by a non-retriggerable cooldown
module infra_kick_timer
  import infra_pkg::*;
#(
  parameter int KICK_PULSE_CYC = 200,
  parameter int COOLDOWN_CYC   = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic kick_out,
  output logic kick_busy
);
  localparam int W = cnt_w(KICK_PULSE_CYC, COOLDOWN_CYC);
  kick_e st, st_n;
  logic [W-1:0] cnt, cnt_n;
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    case (st)
      K_IDLE: if (trigger) begin
        st_n = K_FIRE;
        cnt_n = W'(1);
      end
      K_FIRE: if (cnt == W'(KICK_PULSE_CYC)) begin
        st_n = K_COOL;
        cnt_n = W'(1);
      end else cnt_n = cnt + 1'b1;
      K_COOL: if (cnt == W'(COOLDOWN_CYC)) begin
        st_n = K_IDLE;
        cnt_n = '0;
      end else cnt_n = cnt + 1'b1;
      default: begin
        st_n = K_IDLE;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= K_IDLE;
      cnt <= '0;
      kick_out <= 1'b0;
      kick_busy <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      kick_out <= st_n == K_FIRE;
      kick_busy <= st_n != K_IDLE;
    end
  end
endmodule

// File: rtl/infra_ball_detect.sv
// infra_ball_detect: qualifies beam level into possession, events, hold time and kick trigger
module infra_ball_detect
  import infra_pkg::*;
#(
  parameter int CONFIRM_CYC    = 1000,
  parameter int RELEASE_CYC    = 500,
  parameter int KICK_PULSE_CYC = 200,
  parameter int COOLDOWN_CYC   = 50000,
  parameter int HOLD_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ir_in,
  input  logic              auto_kick_en,
  input  logic              kick_req,
  output logic              ball_present,
  output logic              ball_event,
  output logic              lost_event,
  output logic [HOLD_W-1:0] hold_cnt,
  output logic              kick_out,
  output logic              kick_busy
);
  localparam int CW = cnt_w(CONFIRM_CYC, RELEASE_CYC);
  pres_e st, st_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic gain, lose;
  logic [HOLD_W-1:0] hold_n;
  assign cnt_inc = cnt + 1'b1;
  // EMPTY/HOLD keep the run counter at zero, so they share the arithmetic of CONFIRM/RELEASE
  always_comb begin
    st_n = st;
    cnt_n = '0;
    gain = 1'b0;
    lose = 1'b0;
    if (st == EMPTY || st == CONFIRM) begin
      if (ir_in && cnt_inc == CW'(CONFIRM_CYC)) begin
        st_n = HOLD;
        gain = 1'b1;
      end else if (ir_in) begin
        st_n = CONFIRM;
        cnt_n = cnt_inc;
      end else st_n = EMPTY;
    end else begin
      if (!ir_in && cnt_inc == CW'(RELEASE_CYC)) begin
        st_n = EMPTY;
        lose = 1'b1;
      end else if (!ir_in) begin
        st_n = RELEASE;
        cnt_n = cnt_inc;
      end else st_n = HOLD;
    end
  end
  assign hold_n = gain ? '0 : (ball_present && !(&hold_cnt)) ? hold_cnt + 1'b1 : hold_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= EMPTY;
      cnt <= '0;
      ball_present <= 1'b0;
      ball_event <= 1'b0;
      lost_event <= 1'b0;
      hold_cnt <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      ball_present <= st_n == HOLD || st_n == RELEASE;
      ball_event <= gain;
      lost_event <= lose;
      hold_cnt <= hold_n;
    end
  end
  infra_kick_timer #(
    .KICK_PULSE_CYC(KICK_PULSE_CYC),
    .COOLDOWN_CYC  (COOLDOWN_CYC)
  ) u_kick (
    .clk      (clk),
    .rst      (rst),
    .trigger  ((kick_req | auto_kick_en) & ball_present),
    .kick_out (kick_out),
    .kick_busy(kick_busy)
  );
endmodule

// File: tb/tb_infra_ball_detect.sv
// tb_infra_ball_detect: directed checks of possession qualification, hold count and kick timing
module tb_infra_ball_detect;
  logic clk = 1'b0;
  logic rst, ir_in, auto_kick_en, kick_req;
  logic ball_present, ball_event, lost_event, kick_out, kick_busy;
  logic [3:0] hold_cnt;
  int cmps = 0;
  int errs = 0;
  always #5 clk = ~clk;
  infra_ball_detect #(
    .CONFIRM_CYC(4), .RELEASE_CYC(3), .KICK_PULSE_CYC(2), .COOLDOWN_CYC(5), .HOLD_W(4)
  ) dut (
    .clk(clk), .rst(rst), .ir_in(ir_in), .auto_kick_en(auto_kick_en), .kick_req(kick_req),
    .ball_present(ball_present), .ball_event(ball_event), .lost_event(lost_event),
    .hold_cnt(hold_cnt), .kick_out(kick_out), .kick_busy(kick_busy)
  );
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1; ir_in = 1; kick_req = 1; auto_kick_en = 0;
    tick(3);
    chk("rst_present", 32'(ball_present), 0);
    chk("rst_event", 32'(ball_event), 0);
    chk("rst_lost", 32'(lost_event), 0);
    chk("rst_hold", 32'(hold_cnt), 0);
    chk("rst_kick", 32'(kick_out), 0);
    chk("rst_busy", 32'(kick_busy), 0);
    rst = 0; ir_in = 0;
    tick(2);
    chk("nokick_empty", 32'(kick_out), 0);
    chk("nobusy_empty", 32'(kick_busy), 0);
    kick_req = 0;
    ir_in = 1;
    tick(3);
    chk("short_run", 32'(ball_present), 0);
    ir_in = 0;
    tick(1);
    ir_in = 1;
    tick(3);
    chk("third_high", 32'(ball_present), 0);
    tick(1);
    chk("gain_present", 32'(ball_present), 1);
    chk("gain_event", 32'(ball_event), 1);
    chk("gain_hold0", 32'(hold_cnt), 0);
    tick(1);
    chk("event_width", 32'(ball_event), 0);
    chk("hold1", 32'(hold_cnt), 1);
    chk("no_kick_manual_off", 32'(kick_out), 0);
    ir_in = 0;
    tick(2);
    chk("glitch_present", 32'(ball_present), 1);
    ir_in = 1;
    tick(1);
    chk("glitch_nolost", 32'(lost_event), 0);
    chk("glitch_hold", 32'(hold_cnt), 4);
    ir_in = 0;
    tick(2);
    chk("rel_second_low", 32'(lost_event), 0);
    tick(1);
    chk("lost_event", 32'(lost_event), 1);
    chk("lost_present", 32'(ball_present), 0);
    chk("lost_hold", 32'(hold_cnt), 7);
    tick(2);
    chk("lost_width", 32'(lost_event), 0);
    chk("hold_frozen", 32'(hold_cnt), 7);
    ir_in = 1;
    tick(4);
    chk("sat_gain", 32'(ball_event), 1);
    tick(20);
    chk("sat_hold", 32'(hold_cnt), 15);
    chk("sat_present", 32'(ball_present), 1);
    ir_in = 0;
    tick(3);
    chk("sat_lost_hold", 32'(hold_cnt), 15);
    ir_in = 1;
    tick(4);
    chk("reload_event", 32'(ball_event), 1);
    chk("reload_hold", 32'(hold_cnt), 0);
    ir_in = 0;
    tick(3);
    chk("reload_lost", 32'(lost_event), 1);
    chk("reload_lost_hold", 32'(hold_cnt), 3);
    auto_kick_en = 1; ir_in = 1;
    tick(4);
    chk("auto_gain", 32'(ball_event), 1);
    chk("auto_kick_g0", 32'(kick_out), 0);
    tick(1);
    chk("auto_kick_g1", 32'(kick_out), 1);
    chk("auto_busy_g1", 32'(kick_busy), 1);
    tick(1);
    chk("auto_kick_g2", 32'(kick_out), 1);
    tick(1);
    chk("auto_kick_g3", 32'(kick_out), 0);
    chk("auto_busy_g3", 32'(kick_busy), 1);
    tick(1);
    kick_req = 1;
    tick(3);
    chk("auto_busy_g7", 32'(kick_busy), 1);
    chk("auto_kick_g7", 32'(kick_out), 0);
    kick_req = 0;
    tick(1);
    chk("auto_busy_g8", 32'(kick_busy), 0);
    chk("auto_kick_g8", 32'(kick_out), 0);
    tick(1);
    chk("auto_kick_g9", 32'(kick_out), 1);
    auto_kick_en = 0;
    tick(3);
    chk("cool_kick_g12", 32'(kick_out), 0);
    chk("cool_busy_g12", 32'(kick_busy), 1);
    kick_req = 1;
    tick(1);
    kick_req = 0;
    tick(3);
    chk("cool_end_busy", 32'(kick_busy), 0);
    tick(1);
    chk("req_not_queued", 32'(kick_out), 0);
    chk("req_not_queued_busy", 32'(kick_busy), 0);
    kick_req = 1;
    tick(1);
    chk("manual_kick", 32'(kick_out), 1);
    rst = 1;
    tick(1);
    chk("midrst_kick", 32'(kick_out), 0);
    chk("midrst_busy", 32'(kick_busy), 0);
    chk("midrst_present", 32'(ball_present), 0);
    rst = 0;
    tick(2);
    chk("post_rst_kick", 32'(kick_out), 0);
    chk("post_rst_busy", 32'(kick_busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
